serial_word_tx: RTL and testbench

- Parallel-to-serial bit-stream transmitter; the source side of the one-bit-per-clock serial interface our sequence detectors consume (x in, per-bit evaluation).
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it MSB-first on x, one bit per clk, with framing strobes.
- Alongside each bit it drives div4_exp: the expected divisible-by-4 verdict for the prefix sent so far, so a detector can be checked cycle-by-cycle.

---
 rtl/serial_word_tx.sv | 103 ++++++++++
 tb/tb_serial_word_tx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter: MSB-first bit stream with framing strobes
// and the expected divisible-by-4 verdict of the prefix sent so far.
module serial_word_tx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             x,
  output logic             x_valid,
  output logic             first,
  output logic             last,
  output logic             div4_exp,
  output logic             busy
);

  localparam int unsigned  CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [3:0]    LAST_GAP = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_gap;
  logic            r_prev;

  logic w_shifting;
  logic w_last_bit;
  logic w_accept;

  assign w_shifting = (r_state == S_SHIFT);
  assign w_last_bit = w_shifting && (r_cnt == LAST_IDX);
  assign load_ready = !rst && ((r_state == S_IDLE) || (w_last_bit && (GAP == 0)));
  assign w_accept   = load_valid && load_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_SHIFT;
      S_SHIFT: begin
        if (w_last_bit) begin
          if (GAP != 0)       w_next = S_GAP;
          else if (!w_accept) w_next = S_IDLE;
        end
      end
      S_GAP:   if (r_gap == LAST_GAP) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_prev  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_shift <= data_in;
            r_cnt   <= '0;
          end
        end
        S_SHIFT: begin
          r_prev <= r_shift[WIDTH-1];
          if (w_last_bit) begin
            // back-to-back reload happens on the last-bit edge so no bubble appears
            r_cnt   <= '0;
            r_gap   <= '0;
            r_shift <= w_accept ? data_in : '0;
          end else begin
            r_shift <= {r_shift[WIDTH-2:0], 1'b0};
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        S_GAP:   r_gap <= r_gap + 1'b1;
        default: ;
      endcase
    end
  end

  // r_prev is ignored on the first bit, so no residue crosses a word boundary
  assign x        = w_shifting & r_shift[WIDTH-1];
  assign x_valid  = w_shifting;
  assign first    = w_shifting && (r_cnt == '0);
  assign last     = w_last_bit;
  assign div4_exp = w_shifting && !r_shift[WIDTH-1] && (first || !r_prev);
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: two instances (GAP=0 and GAP=3) checked cycle by cycle
// against a timeline model built from accepted words.
module tb_serial_word_tx;

  localparam int unsigned W = 8;

  typedef struct {
    int cyc;
    bit x;
    bit f;
    bit l;
    bit d;
  } want_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din [2];
  logic         lv  [2];
  int           cyc = 0;
  int           n_chk = 0;
  int           n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, int got, int want);
    n_chk++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int unsigned G = (g == 0) ? 0 : 3;
    localparam string PFX = (g == 0) ? "gap0." : "gap3.";

    logic        rdy, xo, xv, fo, lo, d4, bz;
    logic [15:0] capx = '0;
    logic [15:0] capd = '0;
    want_t       q[$];
    int          free_at = 0;
    int          run = 0;
    bit          en = 0;
    bit          gap_on = 0;

    serial_word_tx #(.WIDTH(W), .GAP(G)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .data_in   (din[g]),
      .load_valid(lv[g]),
      .load_ready(rdy),
      .x         (xo),
      .x_valid   (xv),
      .first     (fo),
      .last      (lo),
      .div4_exp  (d4),
      .busy      (bz)
    );

    always @(negedge clk) begin
      want_t        e;
      bit           hv;
      logic [W-1:0] w;
      int           pre;
      e  = '{default: 0};
      hv = 0;
      if (en) begin
        hv = (q.size() > 0) && (q[0].cyc == cyc);
        if (hv) e = q.pop_front();
        chk({PFX, "x_valid"}, xv, hv);
        chk({PFX, "x"}, xo, e.x);
        chk({PFX, "first"}, fo, e.f);
        chk({PFX, "last"}, lo, e.l);
        chk({PFX, "div4_exp"}, d4, e.d);
        chk({PFX, "load_ready"}, rdy, (!rst && cyc >= free_at));
        chk({PFX, "busy"}, bz, (hv || cyc < free_at));
        if (xv) begin
          capx = {capx[14:0], xo};
          capd = {capd[14:0], d4};
        end
        if (hv && e.f && gap_on) begin
          chk({PFX, "gap_len"}, run, G);
          gap_on = 0;
        end
        if (gap_on && !xv && !rdy) run++;
        if (hv && e.l) begin
          gap_on = 1;
          run    = 0;
        end
      end
      if (rst) begin
        q.delete();
        free_at = cyc + 1;
        en      = 1;
        gap_on  = 0;
      end else if (en && lv[g] && rdy) begin
        w = din[g];
        for (int k = 0; k < W; k++) begin
          pre = int'(w) >> (W - 1 - k);
          q.push_back('{cyc + 1 + k, w[W-1-k], k == 0, k == W - 1, (pre % 4) == 0});
        end
        free_at = (G == 0) ? cyc + W : cyc + W + 1 + G;
      end
    end
  end

  task automatic send(int idx, logic [W-1:0] w);
    int   n;
    logic r;
    din[idx] = w;
    lv[idx]  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      r = (idx == 0) ? g_lane[0].rdy : g_lane[1].rdy;
      n++;
    end while (!r && n < 200);
    if (!r) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    lv[idx] = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    din[0] = 8'hA5;
    din[1] = 8'h3C;
    lv[0]  = 1'b1;
    lv[1]  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    lv[0] = 1'b0;
    lv[1] = 1'b0;
    idle(2);

    send(0, 8'b10011010);
    idle(10);
    chk("single_x", g_lane[0].capx[7:0], 8'b10011010);
    chk("single_div4", g_lane[0].capd[7:0], 8'b00100000);

    send(0, 8'b11001100);
    send(0, 8'b00000000);
    idle(12);
    chk("b2b_x", g_lane[0].capx, 16'b1100110000000000);
    chk("b2b_div4", g_lane[0].capd, 16'b0001000111111111);

    send(1, 8'hB7);
    send(1, 8'h41);
    idle(14);
    chk("gap3_x", g_lane[1].capx, 16'hB741);

    send(0, 8'hFF);
    idle(3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_x_valid", g_lane[0].xv, 0);
    chk("abort_busy", g_lane[0].bz, 0);
    chk("abort_last", g_lane[0].lo, 0);
    idle(1);
    send(0, 8'h5A);
    idle(10);
    chk("after_abort_x", g_lane[0].capx[7:0], 8'h5A);

    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          send(0, ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom));
          idle($urandom_range(0, 2));
        end
      end
      begin
        for (int i = 0; i < 150; i++) begin
          send(1, 8'($urandom));
          idle($urandom_range(0, 3));
        end
      end
    join
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
